// File: rtl/dma_preload_pkg.sv
// Shared types and build-time sizing for the multi-channel preload DMA.
// Widths live here so the descriptor struct and the ports always agree.
package dma_preload_pkg;

    localparam int NUM_CH     = 4;
    localparam int ADDR_W     = 16;
    localparam int BUF_ADDR_W = 13;
    localparam int DATA_W     = 128;
    localparam int LEN_W      = 17;
    localparam int ROWS_W     = 8;
    localparam int MAX_OUT    = 8;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int OUT_W      = $clog2(MAX_OUT) + 1;
    localparam int TOT_W      = LEN_W + ROWS_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     base;
        logic [LEN_W-1:0]      len;
        logic [ROWS_W-1:0]     rows;
        logic [ADDR_W-1:0]     stride;
        logic [BUF_ADDR_W-1:0] buf_base;
    } desc_t;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
    endfunction

endpackage

// File: rtl/dma_preload_ctrl_mc_rr_arbiter.sv
// Round-robin arbiter: lowest-index requester at or after i_ptr, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [N-1:0]     o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign w_masked[gi] = i_req[gi] && (IDX_W'(gi) >= i_ptr);
        end
    endgenerate

    // Nothing at or above the pointer means the search wraps to index 0.
    always_comb begin
        w_pick      = (|w_masked) ? w_masked : i_req;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_pick[k]) begin
                o_grant_oh    = '0;
                o_grant_oh[k] = 1'b1;
                o_grant_idx   = IDX_W'(k);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/dma_preload_ctrl_mc.sv
// Multi-channel 2D strided preload DMA: round-robin over requesters, DDR reads in, dense buffer writes out.
// Optional DMA_PRELOAD_PERF_EN adds perf_cycles / perf_stall counters for the last transfer.
module dma_preload_ctrl_mc
    import dma_preload_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_base,
    input  logic [NUM_CH*LEN_W-1:0]        ch_len,
    input  logic [NUM_CH*ROWS_W-1:0]       ch_rows,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_stride,
    input  logic [NUM_CH*BUF_ADDR_W-1:0]   ch_buf_base,
    output logic [NUM_CH-1:0]              ch_done,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [ADDR_W-1:0]              mem_req_addr,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_W-1:0]              mem_rsp_data,
    output logic                           buf_wr_en,
    output logic [CH_W-1:0]                buf_wr_ch,
    output logic [BUF_ADDR_W-1:0]          buf_wr_addr,
    output logic [DATA_W-1:0]              buf_wr_data,
    output logic                           busy
`ifdef DMA_PRELOAD_PERF_EN
    ,
    output logic [31:0]                    perf_cycles,
    output logic [31:0]                    perf_stall
`endif
);

    state_t                r_state, w_state_next;
    logic [CH_W-1:0]       r_ptr, r_grant;
    logic [NUM_CH-1:0]     r_grant_oh;
    desc_t                 r_desc;
    desc_t                 w_desc [NUM_CH];
    logic [ROWS_W-1:0]     r_row;
    logic [LEN_W-1:0]      r_col;
    logic [ADDR_W-1:0]     r_row_off;
    logic [OUT_W-1:0]      r_out;
    logic [TOT_W-1:0]      r_wr_idx;
    logic                  r_wr_en;
    logic [BUF_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;

    logic                  w_arb_valid;
    logic [NUM_CH-1:0]     w_grant_oh;
    logic [CH_W-1:0]       w_grant_idx;
    logic                  w_grant, w_hs, w_rsp, w_last_col, w_last_row, w_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_desc
            assign w_desc[gi].base     = ch_base[gi*ADDR_W +: ADDR_W];
            assign w_desc[gi].len      = ch_len[gi*LEN_W +: LEN_W];
            assign w_desc[gi].rows     = ch_rows[gi*ROWS_W +: ROWS_W];
            assign w_desc[gi].stride   = ch_stride[gi*ADDR_W +: ADDR_W];
            assign w_desc[gi].buf_base = ch_buf_base[gi*BUF_ADDR_W +: BUF_ADDR_W];
        end
    endgenerate

    rr_arbiter #(.N(NUM_CH), .IDX_W(CH_W)) u_arb (
        .i_req       (ch_req & ~ch_done),
        .i_ptr       (r_ptr),
        .o_valid     (w_arb_valid),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    assign w_grant    = (r_state == S_IDLE) && w_arb_valid;
    assign w_empty    = (w_desc[w_grant_idx].len == '0) || (w_desc[w_grant_idx].rows == '0);
    assign w_hs       = mem_req_valid && mem_req_ready;
    // Beats arriving with nothing outstanding are strays from an abandoned transfer.
    assign w_rsp      = mem_rsp_valid && (r_out != '0);
    assign w_last_col = (r_col == r_desc.len - LEN_W'(1));
    assign w_last_row = (r_row == r_desc.rows - ROWS_W'(1));

    assign mem_req_valid = (r_state == S_ISSUE) && (r_out < OUT_W'(MAX_OUT));
    assign mem_req_addr  = r_desc.base + r_row_off + ADDR_W'(r_col);
    assign ch_done       = (r_state == S_DONE) ? r_grant_oh : '0;
    assign busy          = (r_state != S_IDLE);
    assign buf_wr_en     = r_wr_en;
    assign buf_wr_ch     = r_grant;
    assign buf_wr_addr   = r_wr_addr;
    assign buf_wr_data   = r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_valid) w_state_next = w_empty ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_hs && w_last_col && w_last_row) w_state_next = S_DRAIN;
            S_DRAIN: if (r_out == '0) w_state_next = S_DONE;
            S_DONE:  if (!ch_req[r_grant]) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_desc     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_off  <= '0;
            r_out      <= '0;
            r_wr_idx   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_rsp;
            if (w_rsp) begin
                r_wr_data <= mem_rsp_data;
                r_wr_addr <= r_desc.buf_base + BUF_ADDR_W'(r_wr_idx);
                r_wr_idx  <= r_wr_idx + TOT_W'(1);
            end
            case ({w_hs, w_rsp})
                2'b10:   r_out <= r_out + OUT_W'(1);
                2'b01:   r_out <= r_out - OUT_W'(1);
                default: r_out <= r_out;
            endcase
            if (w_grant) begin
                r_grant    <= w_grant_idx;
                r_grant_oh <= w_grant_oh;
                r_ptr      <= next_ch(w_grant_idx);
                r_desc     <= w_desc[w_grant_idx];
                r_row      <= '0;
                r_col      <= '0;
                r_row_off  <= '0;
                r_wr_idx   <= '0;
            end else if (w_hs) begin
                // Row offset accumulates stride so no multiplier is needed.
                if (w_last_col) begin
                    r_col     <= '0;
                    r_row     <= r_row + ROWS_W'(1);
                    r_row_off <= r_row_off + r_desc.stride;
                end else begin
                    r_col <= r_col + LEN_W'(1);
                end
            end
        end
    end

`ifdef DMA_PRELOAD_PERF_EN
    logic [31:0] r_perf_cycles, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_grant) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_state == S_ISSUE || r_state == S_DRAIN) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (mem_req_valid && !mem_req_ready)          r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_dma_preload_ctrl_mc.sv
// Scoreboard bench for dma_preload_ctrl_mc: a DDR model answers requests with address-tagged data,
// a negedge monitor pops expected read addresses and buffer writes queued by the directed stimulus.
module tb_dma_preload_ctrl_mc;
    import dma_preload_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst = 1'b1;
    logic [NUM_CH-1:0]            ch_req = '0;
    logic [NUM_CH*ADDR_W-1:0]     ch_base = '0;
    logic [NUM_CH*LEN_W-1:0]      ch_len = '0;
    logic [NUM_CH*ROWS_W-1:0]     ch_rows = '0;
    logic [NUM_CH*ADDR_W-1:0]     ch_stride = '0;
    logic [NUM_CH*BUF_ADDR_W-1:0] ch_buf_base = '0;
    logic [NUM_CH-1:0]            ch_done;
    logic                         mem_req_valid;
    logic                         mem_req_ready = 1'b1;
    logic [ADDR_W-1:0]            mem_req_addr;
    logic                         mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0]            mem_rsp_data = '0;
    logic                         buf_wr_en;
    logic [CH_W-1:0]              buf_wr_ch;
    logic [BUF_ADDR_W-1:0]        buf_wr_addr;
    logic [DATA_W-1:0]            buf_wr_data;
    logic                         busy;
`ifdef DMA_PRELOAD_PERF_EN
    logic [31:0]                  perf_cycles, perf_stall;
`endif

    dma_preload_ctrl_mc dut (
        .clk           (clk),
        .rst           (rst),
        .ch_req        (ch_req),
        .ch_base       (ch_base),
        .ch_len        (ch_len),
        .ch_rows       (ch_rows),
        .ch_stride     (ch_stride),
        .ch_buf_base   (ch_buf_base),
        .ch_done       (ch_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_ch     (buf_wr_ch),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
`ifdef DMA_PRELOAD_PERF_EN
        .perf_cycles   (perf_cycles),
        .perf_stall    (perf_stall),
`endif
        .busy          (busy)
    );

    typedef struct {
        logic [CH_W-1:0]       ch;
        logic [BUF_ADDR_W-1:0] ba;
        logic [DATA_W-1:0]     d;
    } wr_t;
    typedef struct {
        int                due;
        logic [ADDR_W-1:0] a;
    } pend_t;

    logic [ADDR_W-1:0] exp_addr_q [$];
    wr_t               exp_wr_q   [$];
    pend_t             pend_q     [$];

    int checks = 0, errors = 0;
    int ncyc = 0, pcyc = 0, lat = 3;
    bit rdy_toggle = 1'b0;
    int stall_cnt = 0, busy_cnt = 0, valid_seen = 0, hs_cnt = 0, last_wr_ncyc = 0, mon_out = 0;

    logic [ADDR_W-1:0]     t2_addr [6] = '{16'h0010, 16'h0011, 16'h0012, 16'h0030, 16'h0031, 16'h0032};
    logic [BUF_ADDR_W-1:0] t2_buf  [6] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001, 13'h0002, 13'h0003};

    function automatic logic [DATA_W-1:0] beat(input logic [ADDR_W-1:0] a);
        return {a, ~a, 32'hDEAD_BEEF, 48'h0, a ^ 16'h5A5A};
    endfunction

    // DDR model: decides ready just after each edge, answers in order after lat cycles.
    always @(posedge clk) begin
        #1;
        pcyc++;
        mem_req_ready = rdy_toggle ? ~mem_req_ready : 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= pcyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = beat(pend_q[0].a);
            void'(pend_q.pop_front());
        end
        if (mem_req_valid && mem_req_ready)
            pend_q.push_back('{due: pcyc + lat, a: mem_req_addr});
    end

    always @(negedge clk) begin : mon
        logic [ADDR_W-1:0] ea;
        wr_t ew;
        ncyc++;
        if (mem_req_valid) valid_seen++;
        if (mem_req_valid && !mem_req_ready) stall_cnt++;
        if (busy && ch_done == '0) busy_cnt++;
        if (mem_req_valid && mem_req_ready) begin
            hs_cnt++;
            checks++;
            if (mon_out >= MAX_OUT) begin
                errors++;
                $display("FAIL outstanding got %0d in flight at new request, limit %0d", mon_out, MAX_OUT);
            end
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL req_addr got unexpected request %h, want none", mem_req_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (mem_req_addr !== ea) begin
                    errors++;
                    $display("FAIL req_addr got %h want %h", mem_req_addr, ea);
                end
            end
        end
        if (mem_req_valid && mem_req_ready && !(mem_rsp_valid && mon_out > 0)) mon_out++;
        else if (!(mem_req_valid && mem_req_ready) && mem_rsp_valid && mon_out > 0) mon_out--;
        if (buf_wr_en) begin
            last_wr_ncyc = ncyc;
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL buf_wr got unexpected write ch%0d addr %h, want none", buf_wr_ch, buf_wr_addr);
            end else begin
                ew = exp_wr_q.pop_front();
                if (buf_wr_ch !== ew.ch || buf_wr_addr !== ew.ba || buf_wr_data !== ew.d) begin
                    errors++;
                    $display("FAIL buf_wr got ch%0d %h %h want ch%0d %h %h",
                             buf_wr_ch, buf_wr_addr, buf_wr_data, ew.ch, ew.ba, ew.d);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_desc(input int ch, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input logic [ROWS_W-1:0] rows, input logic [ADDR_W-1:0] stride,
                            input logic [BUF_ADDR_W-1:0] bb);
        ch_base[ch*ADDR_W +: ADDR_W]             = base;
        ch_len[ch*LEN_W +: LEN_W]                = len;
        ch_rows[ch*ROWS_W +: ROWS_W]             = rows;
        ch_stride[ch*ADDR_W +: ADDR_W]           = stride;
        ch_buf_base[ch*BUF_ADDR_W +: BUF_ADDR_W] = bb;
    endtask

    task automatic push_exp(input int ch, input logic [ADDR_W-1:0] a, input logic [BUF_ADDR_W-1:0] ba);
        wr_t w;
        w.ch = CH_W'(ch);
        w.ba = ba;
        w.d  = beat(a);
        exp_addr_q.push_back(a);
        exp_wr_q.push_back(w);
    endtask

    task automatic check_idle_outputs(input string name);
        logic [255:0] v;
        v = 256'({mem_req_valid, busy, buf_wr_en, ch_done, mem_req_addr, buf_wr_ch, buf_wr_addr, buf_wr_data});
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s got valid=%b busy=%b wr_en=%b done=%b addr=%h wr_addr=%h want all zero",
                     name, mem_req_valid, busy, buf_wr_en, ch_done, mem_req_addr, buf_wr_addr);
        end
    endtask

    task automatic finish_xfer(input int ch);
        int n = 0;
        while (!ch_done[ch] && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (!ch_done[ch]) begin
            errors++;
            $display("FAIL done_timeout ch%0d got ch_done=%b want bit %0d high", ch, ch_done, ch);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain ch%0d got %0d reads %0d writes still expected, want 0",
                     ch, exp_addr_q.size(), exp_wr_q.size());
        end
        checks++;
        if (ncyc <= last_wr_ncyc) begin
            errors++;
            $display("FAIL done_order ch%0d got done at cycle %0d, want after last write %0d", ch, ncyc, last_wr_ncyc);
        end
        $display("xfer ch%0d complete at cycle %0d", ch, ncyc);
        ch_req[ch] = 1'b0;
        tick();
        checks++;
        if (ch_done !== '0) begin
            errors++;
            $display("FAIL done_release ch%0d got ch_done=%b want 0", ch, ch_done);
        end
    endtask

    initial begin
        int n;
        int s0, b0, v0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset_state");

        // T1: ch0, 4 words, one row
        lat = 3;
        set_desc(0, 16'h0100, 17'd4, 8'd1, 16'h0000, 13'h0000);
        for (int i = 0; i < 4; i++) push_exp(0, 16'h0100 + 16'(i), 13'(i));
        ch_req[0] = 1'b1;
        finish_xfer(0);

        // T2: ch2, 3x2 strided, buffer address wraps
        set_desc(2, 16'h0010, 17'd3, 8'd2, 16'h0020, 13'h1FFE);
        for (int i = 0; i < 6; i++) push_exp(2, t2_addr[i], t2_buf[i]);
        ch_req[2] = 1'b1;
        finish_xfer(2);

        // T3: fresh pointer, ch1 and ch3 collide; ch3 must precede ch1's re-request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_desc(1, 16'h0200, 17'd2, 8'd1, 16'h0000, 13'h0010);
        set_desc(3, 16'h0300, 17'd2, 8'd1, 16'h0000, 13'h0020);
        for (int i = 0; i < 2; i++) push_exp(1, 16'h0200 + 16'(i), 13'h0010 + 13'(i));
        ch_req[1] = 1'b1;
        ch_req[3] = 1'b1;
        finish_xfer(1);
        for (int i = 0; i < 2; i++) push_exp(3, 16'h0300 + 16'(i), 13'h0020 + 13'(i));
        ch_req[1] = 1'b1;
        finish_xfer(3);
        for (int i = 0; i < 2; i++) push_exp(1, 16'h0200 + 16'(i), 13'h0010 + 13'(i));
        finish_xfer(1);

        // T4: ready toggling, latency above the outstanding limit
        lat = 12;
        rdy_toggle = 1'b1;
        set_desc(0, 16'h0400, 17'd32, 8'd1, 16'h0000, 13'h0100);
        for (int i = 0; i < 32; i++) push_exp(0, 16'h0400 + 16'(i), 13'h0100 + 13'(i));
        s0 = stall_cnt;
        b0 = busy_cnt;
        ch_req[0] = 1'b1;
        finish_xfer(0);
        rdy_toggle = 1'b0;
`ifdef DMA_PRELOAD_PERF_EN
        checks++;
        if (perf_stall !== 32'(stall_cnt - s0)) begin
            errors++;
            $display("FAIL perf_stall got %0d want %0d", perf_stall, stall_cnt - s0);
        end
        checks++;
        if (perf_cycles !== 32'(busy_cnt - b0)) begin
            errors++;
            $display("FAIL perf_cycles got %0d want %0d", perf_cycles, busy_cnt - b0);
        end
`endif

        // T5: zero-length descriptor skips memory traffic
        lat = 3;
        set_desc(0, 16'h0700, 17'd0, 8'd1, 16'h0000, 13'h0000);
        v0 = valid_seen;
        ch_req[0] = 1'b1;
        n = 0;
        while (!ch_done[0] && n < 2) begin
            tick();
            n++;
        end
        checks++;
        if (!ch_done[0]) begin
            errors++;
            $display("FAIL len0_done got ch_done=%b after %0d cycles want bit 0 within 2", ch_done, n);
        end
        checks++;
        if (valid_seen != v0) begin
            errors++;
            $display("FAIL len0_traffic got %0d request cycles want 0", valid_seen - v0);
        end
        $display("xfer ch0 len0 complete at cycle %0d", ncyc);
        ch_req[0] = 1'b0;
        tick();

        // T6: reset part-way through a 16-word issue; late beats must be dropped
        lat = 10;
        set_desc(0, 16'h0500, 17'd16, 8'd1, 16'h0000, 13'h0000);
        for (int i = 0; i < 5; i++) exp_addr_q.push_back(16'h0500 + 16'(i));
        s0 = hs_cnt;
        ch_req[0] = 1'b1;
        n = 0;
        while (hs_cnt - s0 < 5 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        ch_req[0] = 1'b0;
        tick();
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (16) tick();
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_reqs got %0d of 5 requests missing before reset, want 0", exp_addr_q.size());
        end
        $display("xfer ch0 aborted by reset at cycle %0d", ncyc);

        lat = 2;
        set_desc(0, 16'h0600, 17'd3, 8'd2, 16'h0010, 13'h0040);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                push_exp(0, 16'h0600 + 16'(r * 16 + c), 13'h0040 + 13'(r * 3 + c));
        ch_req[0] = 1'b1;
        finish_xfer(0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion by time limit, want bench to finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_preload_ctrl_mc.md
Name: dma_preload_ctrl_mc

Overview:
- Multi-channel successor to the single-channel weight preload DMA.
- Serves NUM_CH independent preload requesters, one transfer at a time, chosen by round-robin arbitration.
- Each transfer is a 2D strided region: ROWS rows of LEN words, rows STRIDE words apart in DDR. It is read through a valid/ready request port with in-order responses and written densely into the selected channel's on-chip buffer.
- Sits between the layer scheduler (requesters) and the DDR read port / weight and activation buffers.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- ADDR_W, 16, DDR word-address width.
- BUF_ADDR_W, 13, buffer word-address width.
- DATA_W, 128, data word width.
- LEN_W, 17, row-length field width (LEN up to 2^LEN_W-1).
- ROWS_W, 8, row-count field width.
- MAX_OUT, 8, maximum outstanding DDR read requests (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_req  in  NUM_CH  per-channel request level; 4-phase handshake.
- ch_base  in  NUM_CH*ADDR_W  DDR start address; channel i at [i*ADDR_W +: ADDR_W].
- ch_len  in  NUM_CH*LEN_W  words per row.
- ch_rows  in  NUM_CH*ROWS_W  number of rows.
- ch_stride  in  NUM_CH*ADDR_W  DDR distance between row starts.
- ch_buf_base  in  NUM_CH*BUF_ADDR_W  first buffer address.
- ch_done  out  NUM_CH  per-channel done level.
- mem_req_valid  out  1  DDR read request.
- mem_req_ready  in  1  DDR accepts request.
- mem_req_addr  out  ADDR_W  read address.
- mem_rsp_valid  in  1  response beat; in order, always accepted.
- mem_rsp_data  in  DATA_W  response data.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_ch  out  $clog2(NUM_CH)  target channel buffer.
- buf_wr_addr  out  BUF_ADDR_W  buffer address.
- buf_wr_data  out  DATA_W  write data.
- busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset is synchronous and active-high. All outputs, counters and state go to 0; the round-robin pointer goes to 0; state goes to S_IDLE. A reset mid-transfer abandons the transfer, and later stray responses are dropped.
- S_IDLE:
  - Candidates are channels with ch_req=1 and ch_done=0.
  - Round-robin grant: the lowest-index candidate at or after the pointer, wrapping.
  - On grant, the channel's descriptor is latched, the pointer moves to grant+1, and state goes to S_ISSUE next cycle.
  - If LEN==0 or ROWS==0, state goes straight to S_DONE and no memory traffic occurs.
- S_ISSUE:
  - mem_req_valid=1 while outstanding<MAX_OUT.
  - mem_req_addr = base + row*stride + col, modulo 2^ADDR_W.
  - On a valid&&ready handshake: col++. At col==LEN-1, col returns to 0 and row++.
  - After the last request handshake, state goes to S_DRAIN.
  - mem_req_valid and mem_req_addr stay stable until ready is seen.
- Outstanding counter: +1 on request handshake, -1 on mem_rsp_valid; both in the same cycle leave it unchanged. mem_rsp_valid while the counter is 0 is ignored.
- Response path (any state with outstanding>0):
  - One cycle after mem_rsp_valid, buf_wr_en=1 with buf_wr_data equal to that beat's data.
  - buf_wr_addr = buf_base + wr_idx, modulo 2^BUF_ADDR_W; wr_idx counts 0..LEN*ROWS-1.
  - buf_wr_ch is the granted channel.
- S_DRAIN: when outstanding reaches 0 and the final buffer write has issued, go to S_DONE.
- S_DONE:
  - ch_done[grant] goes to 1.
  - It holds until ch_req[grant] is low, then ch_done[grant] returns to 0 and state returns to S_IDLE.
  - Descriptor changes during a transfer are ignored.
  - ch_req dropping mid-transfer does not abort the transfer.
- Total words per transfer is LEN*ROWS, computed at LEN_W+ROWS_W bits with no overflow.
- Throughput is 1 word/cycle when mem_req_ready=1 and response latency ≤ MAX_OUT.

Optional Feature:
- Macro: DMA_PRELOAD_PERF_EN.
- Defined: adds output perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles counts cycles in S_ISSUE and S_DRAIN for the last transfer, cleared on grant.
  - perf_stall counts cycles with mem_req_valid&&!mem_req_ready.
  - Both are frozen in S_DONE and cleared on rst.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dma_preload_pkg:
  - state enum S_IDLE/S_ISSUE/S_DRAIN/S_DONE, 2 bits.
  - descriptor struct {base, len, rows, stride, buf_base}.
  - localparam CH_W = $clog2(NUM_CH).
- Sub-module rr_arbiter: NUM_CH-wide request vector, pointer, one-hot/index grant. It is reused by later multi-requester blocks.

Test Plan:
- Ch0: base=0x0100, len=4, rows=1, buf_base=0, ready=1, latency 3 -> reads 0x0100..0x0103; buffer writes addr 0..3 with the matching data; ch_done[0]=1 one cycle after the last write or later.
- Ch2: base=0x0010, len=3, rows=2, stride=0x20, buf_base=0x1FFE -> reads 0x10,0x11,0x12,0x30,0x31,0x32; buffer addresses 0x1FFE,0x1FFF,0x0000..0x0003 (wrap).
- Ch1 and ch3 request simultaneously, pointer=0 -> ch1 served first, then ch3 after ch1's done and req drop; with ch1 re-requesting, ch3 still precedes it.
- mem_req_ready toggling 1/0 with response latency 12, MAX_OUT=8 -> never more than 8 outstanding; all 32 words of len=32 arrive in order; perf_stall equals the number of ready-low cycles while valid (PERF_EN).
- len=0 on ch0 -> no mem_req_valid; ch_done[0] is high within 2 cycles of the grant.
- rst asserted in S_ISSUE after 5 of 16 requests -> next cycle all outputs are 0 and busy=0; late responses produce no buffer writes; a new request then runs normally.
